// File: rtl/uram_pkg.sv
// Shared constants and types for the true-dual-port UltraRAM block.
package uram_pkg;

  localparam int RD_MODE_NO_CHANGE  = 0;
  localparam int RD_MODE_READ_FIRST = 1;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/uram_rd_pipe.sv
// Read-data pipeline: RD_LAT stages of {data, valid}; data only advances behind a valid slot,
// so the output holds the last returned word across empty slots.
module uram_rd_pipe #(
  parameter int DWIDTH = 72,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] din,
  input  logic              din_vld,
  output logic [DWIDTH-1:0] dout,
  output logic              dout_vld
);

  logic [DWIDTH-1:0] dat_pn [RD_LAT];
  logic [RD_LAT-1:0] vld_pn;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pn <= '0;
      for (int k = 0; k < RD_LAT; k++) dat_pn[k] <= '0;
    end else begin
      // stage 0: memory word capture
      vld_pn[0] <= din_vld;
      if (din_vld) dat_pn[0] <= din;
      // stages 1..RD_LAT-1: output registers
      for (int k = 1; k < RD_LAT; k++) begin
        vld_pn[k] <= vld_pn[k-1];
        if (vld_pn[k-1]) dat_pn[k] <= dat_pn[k-1];
      end
    end
  end

  assign dout     = dat_pn[RD_LAT-1];
  assign dout_vld = vld_pn[RD_LAT-1];

endmodule

// File: rtl/uram_tdp_pipe.sv
// True-dual-port UltraRAM with byte-lane writes, pipelined tagged reads, selectable read
// mode and a sequencer that zeroes the whole array through port A.
module uram_tdp_pipe
  import uram_pkg::*;
#(
  parameter int AWIDTH  = 10,
  parameter int CWIDTH  = 8,
  parameter int NUM_COL = 9,
  parameter int RD_LAT  = 1,
  parameter int RD_MODE = RD_MODE_NO_CHANGE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_start,
  output logic                      clr_busy,
  input  logic                      ena,
  input  logic [NUM_COL-1:0]        wea,
  input  logic [AWIDTH-1:0]         addra,
  input  logic [CWIDTH*NUM_COL-1:0] dina,
  output logic [CWIDTH*NUM_COL-1:0] douta,
  output logic                      douta_vld,
  input  logic                      enb,
  input  logic [NUM_COL-1:0]        web,
  input  logic [AWIDTH-1:0]         addrb,
  input  logic [CWIDTH*NUM_COL-1:0] dinb,
  output logic [CWIDTH*NUM_COL-1:0] doutb,
  output logic                      doutb_vld
);

  localparam int DWIDTH = CWIDTH * NUM_COL;
  localparam int DEPTH  = 2 ** AWIDTH;

  (* ram_style = "ultra" *) logic [DWIDTH-1:0] mem [DEPTH];

  clr_state_t        state, state_nxt;
  logic [AWIDTH-1:0] clr_cnt;
  logic              clr_last;
  logic              clr_we;

  logic              ext_ok;
  logic [NUM_COL-1:0] wea_eff, web_eff, web_mask;
  logic [AWIDTH-1:0] addra_eff;
  logic [DWIDTH-1:0] dina_eff;
  logic              rd_a, rd_b;
  logic [DWIDTH-1:0] rword_a, rword_b;

  assign clr_last = (clr_cnt == {AWIDTH{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) state <= CLR_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLR_IDLE:  if (clr_start) state_nxt = CLR_CLEAR;
      CLR_CLEAR: if (clr_last)  state_nxt = CLR_IDLE;
      default:                  state_nxt = CLR_IDLE;
    endcase
  end

  // A clear write coinciding with rst is suppressed so reset leaves the array untouched.
  always_comb begin
    clr_busy = (state == CLR_CLEAR);
    clr_we   = (state == CLR_CLEAR) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst)                    clr_cnt <= '0;
    else if (state == CLR_CLEAR) clr_cnt <= clr_cnt + 1'b1;
  end

  always_comb begin
    ext_ok    = !clr_busy;
    wea_eff   = '0;
    if (clr_we)              wea_eff = '1;
    else if (ext_ok && ena)  wea_eff = wea;
    addra_eff = clr_busy ? clr_cnt : addra;
    dina_eff  = clr_busy ? '0 : dina;
    web_eff   = (ext_ok && enb) ? web : '0;
    // port A owns any column both ports write at the same address
    web_mask  = (addrb == addra_eff) ? (web_eff & ~wea_eff) : web_eff;
    rd_a      = ext_ok && ena && ((RD_MODE == RD_MODE_READ_FIRST) || (wea == '0));
    rd_b      = ext_ok && enb && ((RD_MODE == RD_MODE_READ_FIRST) || (web == '0));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_COL; i++) begin
      if (wea_eff[i])  mem[addra_eff][i*CWIDTH +: CWIDTH] <= dina_eff[i*CWIDTH +: CWIDTH];
      if (web_mask[i]) mem[addrb][i*CWIDTH +: CWIDTH]     <= dinb[i*CWIDTH +: CWIDTH];
    end
  end

  // Stage 0 samples the word before this edge's writes land, giving old-data reads.
  assign rword_a = mem[addra];
  assign rword_b = mem[addrb];

  uram_rd_pipe #(.DWIDTH(DWIDTH), .RD_LAT(RD_LAT)) u_pipe_a (
    .clk      (clk),
    .rst      (rst),
    .din      (rword_a),
    .din_vld  (rd_a),
    .dout     (douta),
    .dout_vld (douta_vld)
  );

  uram_rd_pipe #(.DWIDTH(DWIDTH), .RD_LAT(RD_LAT)) u_pipe_b (
    .clk      (clk),
    .rst      (rst),
    .din      (rword_b),
    .din_vld  (rd_b),
    .dout     (doutb),
    .dout_vld (doutb_vld)
  );

endmodule

// File: tb/tb_uram_tdp_pipe.sv
// Bench for uram_tdp_pipe: NO_CHANGE and READ_FIRST instances driven in lockstep and
// compared every cycle against a word-level memory model with timed read returns.
module tb_uram_tdp_pipe;

  localparam int AW    = 10;
  localparam int NC    = 9;
  localparam int DW    = 72;
  localparam int LAT   = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, clr_start, ena, enb;
  logic [NC-1:0] wea, web;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, dinb;
  logic [DW-1:0] douta [2];
  logic [DW-1:0] doutb [2];
  logic          douta_vld [2];
  logic          doutb_vld [2];
  logic          clr_busy [2];

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  uram_tdp_pipe #(.AWIDTH(AW), .CWIDTH(8), .NUM_COL(NC), .RD_LAT(LAT), .RD_MODE(0)) u_nc (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(clr_busy[0]),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta[0]), .douta_vld(douta_vld[0]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb[0]), .doutb_vld(doutb_vld[0])
  );

  uram_tdp_pipe #(.AWIDTH(AW), .CWIDTH(8), .NUM_COL(NC), .RD_LAT(LAT), .RD_MODE(1)) u_rf (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(clr_busy[1]),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta[1]), .douta_vld(douta_vld[1]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb[1]), .doutb_vld(doutb_vld[1])
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 40) $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: word array per instance; a read accepted at edge n is due at edge n+LAT-1.
  logic [DW-1:0] mm [2][DEPTH];
  logic [DW-1:0] sd [2][2][8];
  bit            sv [2][2][8];
  logic [DW-1:0] ed [2][2];
  bit            ev [2][2];
  int            clr_left = 0;
  int            edge_n = 0;

  always @(posedge clk) begin : model
    logic [DW-1:0] rv [2];
    bit            rq [2];
    int            now, due;
    now = edge_n % 8;
    due = (edge_n + LAT - 1) % 8;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int p = 0; p < 2; p++) begin
          ed[d][p] = '0;
          ev[d][p] = 1'b0;
          for (int s = 0; s < 8; s++) sv[d][p][s] = 1'b0;
        end
      end else begin
        rq[0] = (clr_left == 0) && ena && (d == 1 || wea == '0);
        rq[1] = (clr_left == 0) && enb && (d == 1 || web == '0);
        rv[0] = mm[d][addra];
        rv[1] = mm[d][addrb];
        if (clr_left > 0) mm[d][DEPTH - clr_left] = '0;
        else begin
          for (int c = 0; c < NC; c++) if (enb && web[c]) mm[d][addrb][c*8 +: 8] = dinb[c*8 +: 8];
          for (int c = 0; c < NC; c++) if (ena && wea[c]) mm[d][addra][c*8 +: 8] = dina[c*8 +: 8];
        end
        for (int p = 0; p < 2; p++) begin
          sv[d][p][due] = rq[p];
          sd[d][p][due] = rv[p];
          ev[d][p] = sv[d][p][now];
          if (ev[d][p]) ed[d][p] = sd[d][p][now];
          sv[d][p][now] = 1'b0;
        end
      end
    end
    if (rst)               clr_left = 0;
    else if (clr_left > 0) clr_left--;
    else if (clr_start)    clr_left = DEPTH;
    edge_n++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("busy[%0d]", d), clr_busy[d], clr_left > 0);
        chk($sformatf("douta[%0d]", d), douta[d], ed[d][0]);
        chk($sformatf("douta_vld[%0d]", d), douta_vld[d], ev[d][0]);
        chk($sformatf("doutb[%0d]", d), doutb[d], ed[d][1]);
        chk($sformatf("doutb_vld[%0d]", d), doutb_vld[d], ev[d][1]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0; clr_start = 1'b0;
  endtask

  task automatic wr_a(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NC-1:0] we);
    ena = 1'b1; wea = we; addra = a; dina = d;
    step();
    idle();
  endtask

  task automatic rd_a(input logic [AW-1:0] a);
    ena = 1'b1; wea = '0; addra = a;
    step();
    idle();
  endtask

  task automatic rd_b(input logic [AW-1:0] a);
    enb = 1'b1; web = '0; addrb = a;
    step();
    idle();
  endtask

  function automatic logic [DW-1:0] rnd72();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  function automatic logic [NC-1:0] rnd_we();
    int unsigned r;
    r = $urandom_range(0, 3);
    if (r == 0) return '0;
    if (r == 1) return '1;
    return NC'($urandom());
  endfunction

  task automatic run_clear(input bit noise, output int n);
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    n = 0;
    while (clr_busy[0] && n < 2000) begin
      n++;
      if (noise) begin
        ena = 1'b1; wea = '1; addra = AW'($urandom()); dina = rnd72();
        enb = 1'b1; web = rnd_we(); addrb = AW'($urandom()); dinb = rnd72();
      end
      step();
    end
    idle();
  endtask

  task automatic rd_both_chk(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd_a(a);
    repeat (LAT - 1) step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s[%0d]", nm, d), douta[d], exp);
      chk($sformatf("%s_vld[%0d]", nm, d), douta_vld[d], 1'b1);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n, nv;
    logic [DW-1:0] acc, pa, pb;
    logic [7:0] b;

    rst = 1'b1; idle();
    addra = '0; addrb = '0; dina = '0; dinb = '0;
    repeat (3) step();
    chk_en = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_douta[%0d]", d), douta[d], '0);
      chk($sformatf("rst_vld[%0d]", d), douta_vld[d] | doutb_vld[d], 1'b0);
      chk($sformatf("rst_busy[%0d]", d), clr_busy[d], 1'b0);
    end
    rst = 1'b0;
    step();

    run_clear(1'b0, n);
    chk("clear0_cycles", n, 1024);

    // basic write via A, read via B
    wr_a(5, 72'h1_2345_6789, '1);
    rd_b(5);
    repeat (LAT - 1) step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rdB5[%0d]", d), doutb[d], 72'h1_2345_6789);
      chk($sformatf("rdB5_vld[%0d]", d), doutb_vld[d], 1'b1);
    end
    step();
    chk("rdB5_vld_drop", doutb_vld[1], 1'b0);
    chk("rdB5_hold", doutb[1], 72'h1_2345_6789);

    // byte-lane write over a zero word
    wr_a(0, '1, 9'h0F0);
    rd_both_chk("lanes", 0, 72'h00FFFFFFFF00000000);

    // same-address writes on both ports
    pa = 72'hA1A2A3A4A5A6A7A8A9;
    pb = 72'hB1B2B3B4B5B6B7B8B9;
    ena = 1'b1; enb = 1'b1; wea = '1; web = '1; addra = 7; addrb = 7; dina = pa; dinb = pb;
    step(); idle();
    rd_both_chk("both7", 7, pa);
    ena = 1'b1; enb = 1'b1; wea = 9'h00F; web = 9'h1F8; addra = 8; addrb = 8;
    step(); idle();
    rd_both_chk("split8", 8, 72'hB1B2B3B4B5A6A7A8A9);

    // write-with-read: READ_FIRST returns old data, NO_CHANGE issues nothing
    wr_a(3, {9{8'h55}}, '1);
    ena = 1'b1; wea = '0; addra = 0;
    step();
    wea = '1; addra = 3; dina = {9{8'hAA}};
    step(); idle();
    repeat (LAT - 1) step();
    chk("rf_old", douta[1], {9{8'h55}});
    chk("rf_vld", douta_vld[1], 1'b1);
    chk("nc_vld", douta_vld[0], 1'b0);
    chk("nc_hold", douta[0], 72'h00FFFFFFFF00000000);
    rd_both_chk("new3", 3, {9{8'hAA}});

    // random traffic on a small window to force collisions
    for (int i = 0; i < 1500; i++) begin
      ena = ($urandom_range(0, 3) != 0); wea = rnd_we(); addra = AW'($urandom_range(0, 15)); dina = rnd72();
      enb = ($urandom_range(0, 3) != 0); web = rnd_we(); addrb = AW'($urandom_range(0, 15)); dinb = rnd72();
      step();
    end
    idle();
    repeat (LAT + 1) step();

    // fill, then clear with ignored traffic
    for (int i = 0; i < DEPTH / 2; i++) begin
      ena = 1'b1; wea = '1; addra = AW'(i);             dina = rnd72() | 72'h1;
      enb = 1'b1; web = '1; addrb = AW'(i + DEPTH / 2); dinb = rnd72() | 72'h1;
      step();
    end
    idle();
    run_clear(1'b1, n);
    chk("clear1_cycles", n, 1024);
    acc = '0; nv = 0;
    for (int i = 0; i < DEPTH + LAT; i++) begin
      if (i < DEPTH) begin
        ena = 1'b1; wea = '0; addra = AW'(i);
        enb = 1'b1; web = '0; addrb = AW'(DEPTH - 1 - i);
      end else idle();
      step();
      for (int d = 0; d < 2; d++) begin
        if (douta_vld[d]) begin acc |= douta[d]; nv++; end
        if (doutb_vld[d]) begin acc |= doutb[d]; nv++; end
      end
    end
    chk("clear_all_zero", acc, '0);
    chk("clear_read_count", nv, 4 * DEPTH);

    // reset part-way through a clear
    for (int i = 0; i < 100; i++) begin
      b = 8'(i + 1);
      ena = 1'b1; wea = '1; addra = AW'(i); dina = {9{b}};
      b = 8'(i + 101);
      enb = 1'b1; web = '1; addrb = AW'(i + 100); dinb = {9{b}};
      step();
    end
    idle();
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (100) step();
    rst = 1'b1;
    step();
    chk("rstclr_busy0", clr_busy[0], 1'b0);
    chk("rstclr_busy1", clr_busy[1], 1'b0);
    rst = 1'b0;
    step();
    rd_both_chk("part98", 98, '0);
    rd_both_chk("part99", 99, '0);
    rd_both_chk("part100", 100, {9{8'd101}});
    rd_both_chk("part101", 101, {9{8'd102}});
    rd_both_chk("part199", 199, {9{8'd200}});

    for (int i = 0; i < 300; i++) begin
      ena = ($urandom_range(0, 1) != 0); wea = rnd_we(); addra = AW'($urandom_range(90, 110)); dina = rnd72();
      enb = ($urandom_range(0, 1) != 0); web = rnd_we(); addrb = AW'($urandom_range(90, 110)); dinb = rnd72();
      step();
    end
    idle();
    repeat (LAT + 2) step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
